// File: rtl/dac_pkg.sv
// Shared types and widths for the DAC SPI transmitter.
// Holds the FSM state encoding and a small max helper.
package dac_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned CTRL_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dac_spi_tx_clk_div.sv
// SCLK half-period tick generator: one-cycle tick every CLK_DIV
// enabled cycles, restarting from zero whenever enable drops.
module dac_clk_div #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// 16-bit SPI frame transmitter for a 12-bit DAC ({CTRL, sample}).
// Optional LDAC strobe in the CS gap when DAC_LDAC_EN is defined.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int unsigned       CLK_DIV = 25,
  parameter logic [CTRL_W-1:0] CTRL    = 4'b0011,
  parameter int unsigned       CS_GAP  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              DAC_CS_N,
  output logic              DAC_SCLK,
`ifdef DAC_LDAC_EN
  output logic              DAC_LDAC_N,
`endif
  output logic              DAC_DIN
);

`ifdef DAC_LDAC_EN
  localparam int unsigned GAP_LEN = max_u(CS_GAP, CLK_DIV + 1);
`else
  localparam int unsigned GAP_LEN = CS_GAP;
`endif
  localparam int unsigned GW = $clog2(GAP_LEN + 1);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [3:0]         bit_q, bit_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               din_q, din_d;
  logic               done_q, done_d;
  logic [FRAME_W-1:0] frame;
  logic               div_en;
  logic               tick;

  assign frame  = {CTRL, in_data};
  assign div_en = (state_q == SHIFT) || (state_q == HOLD);

  dac_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clock (clock),
    .reset (reset),
    .en_i  (div_en),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          sh_d    = {frame[FRAME_W-2:0], 1'b0};
          din_d   = frame[FRAME_W-1];
          bit_d   = 4'd15;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = !sclk_q;
          // data moves only on the falling SCLK edge
          if (sclk_q) begin
            if (bit_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              bit_d = bit_q - 4'd1;
              din_d = sh_q[FRAME_W-1];
              sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
          din_d   = 1'b0;
          done_d  = 1'b1;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_LEN - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

`ifdef DAC_LDAC_EN
  logic ldac_q, ldac_d;

  // low for the first CLK_DIV gap cycles, lagging CS_N by one
  assign ldac_d = !((state_q == GAP) && (gap_q < GW'(CLK_DIV)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ldac_q <= 1'b1;
    end else begin
      ldac_q <= ldac_d;
    end
  end

  assign DAC_LDAC_N = ldac_q;
`endif

  assign in_ready = (state_q == IDLE);
  assign busy     = !in_ready;
  assign done     = done_q;
  assign DAC_CS_N = cs_n_q;
  assign DAC_SCLK = sclk_q;
  assign DAC_DIN  = din_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: frame content, timing, reset abort.
// Build with DAC_LDAC_EN to add the LDAC strobe checks.
module tb_dac_spi_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] in_data;
  logic        in_valid;
  int          sel;
  int          compared = 0;
  int          mismatched = 0;

  logic cs_a, sclk_a, din_a, done_a, rdy_a, busy_a;
  logic cs_b, sclk_b, din_b, done_b, rdy_b, busy_b;
  logic cs, sclk, din, done, rdy, busy, all_rdy;
`ifdef DAC_LDAC_EN
  logic ldac_a, ldac_b, ldac_c;
  logic cs_c, sclk_c, din_c, done_c, rdy_c, busy_c;
`endif

  always #5 clock = ~clock;

  dac_spi_tx #(.CLK_DIV(2), .CTRL(4'b0011), .CS_GAP(4)) u_a (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_a), .busy(busy_a), .done(done_a),
    .DAC_CS_N(cs_a), .DAC_SCLK(sclk_a),
`ifdef DAC_LDAC_EN
    .DAC_LDAC_N(ldac_a),
`endif
    .DAC_DIN(din_a)
  );

  dac_spi_tx #(.CLK_DIV(1), .CTRL(4'b0011), .CS_GAP(4)) u_b (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_b), .busy(busy_b), .done(done_b),
    .DAC_CS_N(cs_b), .DAC_SCLK(sclk_b),
`ifdef DAC_LDAC_EN
    .DAC_LDAC_N(ldac_b),
`endif
    .DAC_DIN(din_b)
  );

`ifdef DAC_LDAC_EN
  dac_spi_tx #(.CLK_DIV(2), .CTRL(4'b0011), .CS_GAP(1)) u_c (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_c), .busy(busy_c), .done(done_c),
    .DAC_CS_N(cs_c), .DAC_SCLK(sclk_c),
    .DAC_LDAC_N(ldac_c),
    .DAC_DIN(din_c)
  );
`endif

  always_comb begin
    {cs, sclk, din, done, rdy, busy} =
      {cs_a, sclk_a, din_a, done_a, rdy_a, busy_a};
    all_rdy = rdy_a && rdy_b;
    if (sel == 1) begin
      {cs, sclk, din, done, rdy, busy} =
        {cs_b, sclk_b, din_b, done_b, rdy_b, busy_b};
    end
`ifdef DAC_LDAC_EN
    all_rdy = rdy_a && rdy_b && rdy_c;
    if (sel == 2) begin
      {cs, sclk, din, done, rdy, busy} =
        {cs_c, sclk_c, din_c, done_c, rdy_c, busy_c};
    end
`endif
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!all_rdy && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", 32'(n < 1000), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  // Count CS_N-high cycles, then capture one CS_N-low window.
  // Returns at the negedge of the first CS_N-high cycle after it.
  task automatic watch(input int pulse_at, output logic [15:0] w,
                       output int e, output int lo, output int hi,
                       output logic dn);
    logic p;
    int   n;
    w = '0; e = 0; lo = 0; hi = 0; p = 1'b0; n = 0;
    while (cs && n < 500) begin
      hi++;
      @(negedge clock);
      n++;
    end
    while (!cs && n < 500) begin
      if (sclk && !p) begin
        w = {w[14:0], din};
        e++;
      end
      p = sclk;
      lo++;
      if (pulse_at >= 0) begin
        in_valid = (lo == pulse_at);
        if (lo == pulse_at) in_data = 12'hABC;
      end
      @(negedge clock);
      n++;
    end
    dn = done;
    check("watch_timeout", 32'(n < 500), 32'd1);
  endtask

  logic [15:0] w;
  int          e, lo, hi, lo1, idle_lo, n;
  logic        dn, p;

  initial begin
    sel = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clock);
    check("rst_cs_n", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(rdy), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // single frame, CLK_DIV=2
    in_data = 12'hA5C;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("first_cs_n", 32'(cs), 32'd0);
    check("first_sclk", 32'(sclk), 32'd0);
    check("first_din", 32'(din), 32'd0);
    check("first_ready", 32'(rdy), 32'd0);
    check("first_busy", 32'(busy), 32'd1);
    watch(-1, w, e, lo, hi, dn);
    check("a5c_word", 32'(w), 32'h3A5C);
    check("a5c_edges", 32'(e), 32'd16);
    check("a5c_cs_low", 32'(lo), 32'd66);
    check("a5c_done", 32'(dn), 32'd1);
    check("a5c_cs_up", 32'(cs), 32'd1);
    @(negedge clock);
    check("a5c_done_pulse", 32'(done), 32'd0);
    check("a5c_din_idle", 32'(din), 32'd0);
    wait_idle();

    // back-to-back with in_valid held high
    in_data = 12'h000;
    in_valid = 1'b1;
    @(negedge clock);
    in_data = 12'hFFF;
    watch(-1, w, e, lo, hi, dn);
    lo1 = lo;
    check("b2b_word0", 32'(w), 32'h3000);
    check("b2b_edges0", 32'(e), 32'd16);
    watch(-1, w, e, lo, hi, dn);
    in_valid = 1'b0;
    // gap cycles plus the idle cycle in which the next sample is taken
    check("b2b_cs_high", 32'(hi), 32'd5);
    check("b2b_period", 32'(lo1 + hi), 32'd71);
    check("b2b_word1", 32'(w), 32'h3FFF);
    check("b2b_edges1", 32'(e), 32'd16);
    wait_idle();

    // in_valid pulsed mid-frame must be dropped
    in_data = 12'h123;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    watch(20, w, e, lo, hi, dn);
    in_valid = 1'b0;
    check("ign_word", 32'(w), 32'h3123);
    idle_lo = 0;
    repeat (80) begin
      @(negedge clock);
      if (!cs) idle_lo++;
    end
    check("ign_no_frame", 32'(idle_lo), 32'd0);
    wait_idle();

    // reset at the 7th SCLK rising edge
    in_data = 12'hFFF;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    e = 0; p = 1'b0; n = 0;
    while (n < 200) begin
      if (sclk && !p) e++;
      p = sclk;
      if (e == 7) break;
      @(negedge clock);
      n++;
    end
    check("abort_edge7", 32'(e), 32'd7);
    check("abort_din_pre", 32'(din), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_din", 32'(din), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(rdy), 32'd1);
    @(negedge clock);
    check("abort_done_late", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    in_data = 12'h5A5;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    watch(-1, w, e, lo, hi, dn);
    check("post_word", 32'(w), 32'h35A5);
    check("post_edges", 32'(e), 32'd16);
    check("post_cs_low", 32'(lo), 32'd66);
    wait_idle();

    // CLK_DIV=1 instance
    sel = 1;
    in_data = 12'h800;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    watch(-1, w, e, lo, hi, dn);
    check("div1_word", 32'(w), 32'h3800);
    check("div1_edges", 32'(e), 32'd16);
    check("div1_cs_low", 32'(lo), 32'd33);
    check("div1_done", 32'(dn), 32'd1);
    wait_idle();

`ifdef DAC_LDAC_EN
    // CLK_DIV=2, CS_GAP=1: gap stretched to 3 for the LDAC strobe
    sel = 2;
    in_data = 12'h456;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    watch(-1, w, e, lo, hi, dn);
    check("ldac_word", 32'(w), 32'h3456);
    check("ldac_done", 32'(dn), 32'd1);
    check("ldac_t0", 32'(ldac_c), 32'd1);
    @(negedge clock);
    check("ldac_t1", 32'(ldac_c), 32'd0);
    check("ldac_rdy_t1", 32'(rdy), 32'd0);
    @(negedge clock);
    check("ldac_t2", 32'(ldac_c), 32'd0);
    check("ldac_rdy_t2", 32'(rdy), 32'd0);
    @(negedge clock);
    check("ldac_t3", 32'(ldac_c), 32'd1);
    check("ldac_rdy_t3", 32'(rdy), 32'd1);
    wait_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
